// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage boundaries.
// Holds the payload layouts and widths for each boundary, plus the occupancy type.
package pipe_pkg;

  typedef logic [1:0] occ_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } if_id_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] imm;
    logic [4:0]  alu_op;
    logic [4:0]  wreg;
    logic        regwen;
    logic        hi_we;
    logic        lo_we;
    logic        cp0_we;
    logic [4:0]  cp0_addr;
  } id_ex_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] res;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [4:0]  wreg;
    logic        regwen;
    logic        hi_we;
    logic        lo_we;
    logic        cp0_we;
    logic [4:0]  cp0_addr;
    logic        mem_rd;
    logic        mem_wr;
  } ex_mem_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] res;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [4:0]  wreg;
    logic        regwen;
    logic        hi_we;
    logic        lo_we;
  } mem_wb_t;

  localparam int IF_ID_W  = $bits(if_id_t);
  localparam int ID_EX_W  = $bits(id_ex_t);
  localparam int EX_MEM_W = $bits(ex_mem_t);
  localparam int MEM_WB_W = $bits(mem_wb_t);

endpackage

// File: rtl/pipe_seg_slot.sv
// One storage slot of a pipeline segment: a valid bit plus a payload register.
// clr drops the valid bit, load captures a new entry, data_clr restores RST_DATA.
module pipe_seg_slot #(
  parameter int               WIDTH    = 128,
  parameter logic [WIDTH-1:0] RST_DATA = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             clr,
  input  logic             data_clr,
  input  logic [WIDTH-1:0] load_data,
  output logic             v,
  output logic [WIDTH-1:0] data
);

  logic             v_q, v_d;
  logic [WIDTH-1:0] data_q, data_d;

  // Next-state: clear wins over load; data restore is independent of the valid bit
  always_comb begin
    v_d    = v_q;
    data_d = data_q;
    if (clr) begin
      v_d = 1'b0;
    end else if (load) begin
      v_d    = 1'b1;
      data_d = load_data;
    end
    if (data_clr) begin
      data_d = RST_DATA;
    end
  end

  // Slot registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      v_q    <= 1'b0;
      data_q <= RST_DATA;
    end else begin
      v_q    <= v_d;
      data_q <= data_d;
    end
  end

  assign v    = v_q;
  assign data = data_q;

endmodule

// File: rtl/pipe_seg_skid.sv
// Pipeline segment register with valid/ready handshake, flush and a 2-entry skid.
// Main slot M drives the outputs; skid slot S catches one entry while M is stalled,
// so in_ready comes from a flop and never depends combinationally on out_ready.
// Optional build macro: PIPE_SEG_CLR_ON_FLUSH_EN -- flush also restores the data
// registers to RST_DATA (otherwise only the valid bits are cleared).
module pipe_seg_skid
  import pipe_pkg::*;
#(
  parameter int               WIDTH    = 128,
  parameter logic [WIDTH-1:0] RST_DATA = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  logic             m_v, s_v;
  logic [WIDTH-1:0] m_data, s_data;
  logic             m_load, m_clr, s_load, s_clr, data_clr;
  logic [WIDTH-1:0] m_load_data;
  logic             s_v_next;
  logic             in_ready_q, in_ready_d;
  logic             in_fire, out_fire;
  occ_t             occ;

  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = m_v & out_ready;

  // Slot control: decide which slot loads or clears this cycle
  always_comb begin
    m_load      = 1'b0;
    m_clr       = 1'b0;
    s_load      = 1'b0;
    s_clr       = 1'b0;
    m_load_data = in_data;
    data_clr    = 1'b0;
    if (flush) begin
      // An out_fire this cycle is still consumed; nothing is re-presented
      m_clr = 1'b1;
      s_clr = 1'b1;
`ifdef PIPE_SEG_CLR_ON_FLUSH_EN
      data_clr = 1'b1;
`endif
    end else if (!m_v) begin
      m_load = in_fire;
    end else if (!s_v) begin
      if (out_fire) begin
        m_load = in_fire;
        m_clr  = !in_fire;
      end else begin
        s_load = in_fire;
      end
    end else if (out_fire) begin
      // Skid full means in_ready is low, so only the S->M shift can happen
      m_load      = 1'b1;
      m_load_data = s_data;
      s_clr       = 1'b1;
    end
  end

  // Predict the skid valid bit so in_ready can be registered alongside it
  always_comb begin
    s_v_next = s_v;
    if (s_clr) begin
      s_v_next = 1'b0;
    end else if (s_load) begin
      s_v_next = 1'b1;
    end
    in_ready_d = !s_v_next;
  end

  // Registered in_ready, mirroring !s_v
  always_ff @(posedge clk) begin
    if (reset) begin
      in_ready_q <= 1'b1;
    end else begin
      in_ready_q <= in_ready_d;
    end
  end

  pipe_seg_slot #(.WIDTH(WIDTH), .RST_DATA(RST_DATA)) u_slot_m (
    .clk       (clk),
    .reset     (reset),
    .load      (m_load),
    .clr       (m_clr),
    .data_clr  (data_clr),
    .load_data (m_load_data),
    .v         (m_v),
    .data      (m_data)
  );

  pipe_seg_slot #(.WIDTH(WIDTH), .RST_DATA(RST_DATA)) u_slot_s (
    .clk       (clk),
    .reset     (reset),
    .load      (s_load),
    .clr       (s_clr),
    .data_clr  (data_clr),
    .load_data (in_data),
    .v         (s_v),
    .data      (s_data)
  );

  // The skid slot may only hold an entry while the main slot is occupied
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(s_v && !m_v));
    end
  end

  assign occ       = {1'b0, m_v} + {1'b0, s_v};
  assign occupancy = occ;
  assign in_ready  = in_ready_q;
  assign out_valid = m_v;
  assign out_data  = m_data;

endmodule

// File: tb/tb_pipe_seg_skid.sv
// Directed vector table plus hand sequences and a queue-model random run
// for pipe_seg_skid. Honours PIPE_SEG_CLR_ON_FLUSH_EN when defined.
module tb_pipe_seg_skid;

  localparam int          W    = 32;
  localparam logic [W-1:0] RSTD = 32'h5EED_0000;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [1:0]    occupancy;

  int checks = 0;
  int errors = 0;
  int prints = 0;

  pipe_seg_skid #(.WIDTH(W), .RST_DATA(RSTD)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         iv;
    logic [W-1:0] d;
    logic         ordy;
    logic         fl;
    logic         ev;
    logic         cd;
    logic [W-1:0] ed;
    logic         eir;
    logic [1:0]   eocc;
  } vec_t;

  vec_t vecs[$];

  // Data expected after a flush that left old contents 'old' in the main slot
  function automatic logic [W-1:0] flushed(logic [W-1:0] old);
`ifdef PIPE_SEG_CLR_ON_FLUSH_EN
    return RSTD;
`else
    return old;
`endif
  endfunction

  task automatic add(logic iv, logic [W-1:0] d, logic ordy, logic fl,
                     logic ev, logic cd, logic [W-1:0] ed, logic eir, logic [1:0] eocc);
    vec_t v;
    v.iv = iv; v.d = d; v.ordy = ordy; v.fl = fl;
    v.ev = ev; v.cd = cd; v.ed = ed; v.eir = eir; v.eocc = eocc;
    vecs.push_back(v);
  endtask

  task automatic step(logic iv, logic [W-1:0] d, logic ordy, logic fl);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic check(string name, logic ev, logic cd, logic [W-1:0] ed,
                       logic eir, logic [1:0] eocc);
    checks++;
    if (out_valid !== ev || in_ready !== eir || occupancy !== eocc ||
        (cd && out_data !== ed)) begin
      errors++;
      if (prints < 20) begin
        $display("FAIL %s: got valid=%b ready=%b occ=%0d data=%h, expected valid=%b ready=%b occ=%0d data=%h%s",
                 name, out_valid, in_ready, occupancy, out_data, ev, eir, eocc, ed,
                 cd ? "" : " (data not checked)");
      end
      prints++;
    end
  endtask

  logic [W-1:0] q[$];

  initial begin
    reset = 1'b1; in_valid = 1'b1; in_data = 32'hAAAA_AAAA;
    out_ready = 1'b0; flush = 1'b0;

    // Reset held two cycles with a valid entry offered
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0; in_valid = 1'b0;
    check("reset", 1'b0, 1'b1, RSTD, 1'b1, 2'd0);
    $display("reset: valid=%b ready=%b occ=%0d data=%h", out_valid, in_ready, occupancy, out_data);

    // Streaming: one entry per cycle with out_ready high
    for (int k = 1; k <= 8; k++) begin
      add(1'b1, W'(k), 1'b1, 1'b0, 1'b1, 1'b1, W'(k), 1'b1, 2'd1);
    end
    add(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b1, 2'd0);
    // Stall fill then drain with no gap
    add(1'b1, 32'h10, 1'b0, 1'b0, 1'b1, 1'b1, 32'h10, 1'b1, 2'd1);
    add(1'b1, 32'h11, 1'b0, 1'b0, 1'b1, 1'b1, 32'h10, 1'b0, 2'd2);
    add(1'b1, 32'h12, 1'b0, 1'b0, 1'b1, 1'b1, 32'h10, 1'b0, 2'd2);
    add(1'b1, 32'h12, 1'b1, 1'b0, 1'b1, 1'b1, 32'h11, 1'b1, 2'd1);
    add(1'b1, 32'h12, 1'b1, 1'b0, 1'b1, 1'b1, 32'h12, 1'b1, 2'd1);
    add(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b1, 2'd0);
    // Flush of a full segment with an entry offered
    add(1'b1, 32'h20, 1'b0, 1'b0, 1'b1, 1'b1, 32'h20, 1'b1, 2'd1);
    add(1'b1, 32'h21, 1'b0, 1'b0, 1'b1, 1'b1, 32'h20, 1'b0, 2'd2);
    add(1'b1, 32'h22, 1'b0, 1'b1, 1'b0, 1'b1, flushed(32'h20), 1'b1, 2'd0);
    add(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1, flushed(32'h20), 1'b1, 2'd0);
    // Flush drops an in_fire into an empty segment
    add(1'b1, 32'h23, 1'b1, 1'b1, 1'b0, 1'b1, flushed(32'h20), 1'b1, 2'd0);
    add(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b1, 2'd0);
    // Flush coinciding with out_fire: consumed once, not re-presented
    add(1'b1, 32'h30, 1'b0, 1'b0, 1'b1, 1'b1, 32'h30, 1'b1, 2'd1);
    add(1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b1, flushed(32'h30), 1'b1, 2'd0);
    add(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b1, 2'd0);

    foreach (vecs[i]) begin
      step(vecs[i].iv, vecs[i].d, vecs[i].ordy, vecs[i].fl);
      check($sformatf("vec%0d", i), vecs[i].ev, vecs[i].cd, vecs[i].ed, vecs[i].eir, vecs[i].eocc);
      $display("vec%0d: in v=%b d=%h ordy=%b fl=%b -> valid=%b data=%h ready=%b occ=%0d",
               i, vecs[i].iv, vecs[i].d, vecs[i].ordy, vecs[i].fl,
               out_valid, out_data, in_ready, occupancy);
    end

    // Reset while full with an entry offered discards everything
    step(1'b1, 32'h40, 1'b0, 1'b0);
    check("midrst_fill1", 1'b1, 1'b1, 32'h40, 1'b1, 2'd1);
    step(1'b1, 32'h41, 1'b0, 1'b0);
    check("midrst_fill2", 1'b1, 1'b1, 32'h40, 1'b0, 2'd2);
    reset = 1'b1;
    step(1'b1, 32'h42, 1'b1, 1'b1);
    check("midrst", 1'b0, 1'b1, RSTD, 1'b1, 2'd0);
    reset = 1'b0;
    step(1'b0, '0, 1'b1, 1'b0);
    check("midrst_after", 1'b0, 1'b1, RSTD, 1'b1, 2'd0);
    $display("mid-transfer reset: valid=%b ready=%b occ=%0d data=%h", out_valid, in_ready, occupancy, out_data);

    // Random traffic against a FIFO model of depth 2
    for (int c = 0; c < 10000; c++) begin
      logic         iv, ordy, fl, m_ir, m_ov;
      logic [W-1:0] d;
      iv   = 1'($urandom_range(1));
      ordy = 1'($urandom_range(1));
      fl   = ($urandom_range(99) == 0);
      d    = $urandom;
      m_ir = (q.size() < 2);
      m_ov = (q.size() > 0);
      if (fl) begin
        q.delete();
      end else begin
        if (m_ov && ordy) void'(q.pop_front());
        if (iv && m_ir) q.push_back(d);
      end
      step(iv, d, ordy, fl);
      check("rand", q.size() > 0, q.size() > 0, (q.size() > 0) ? q[0] : '0,
            q.size() < 2, 2'(q.size()));
    end
    $display("random: 10000 cycles done");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
